axis_matvec_arbiter: RTL and testbench

- Shares one AXI-Stream matrix-vector engine between N independent AXI-Stream requesters.
- Round-robin arbitration selects the requester whose beat (one full {k,x} job) is issued to the engine.
- The source ID of each issued job is recorded in an in-flight tag FIFO. The engine returns results in order, and each result is routed back to the requester that issued it.
- Sits between requester masters and the engine's s/m ports.

---
 rtl/axis_matvec_arbiter.sv | 156 +++++++++++++++
 tb/tb_axis_matvec_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_matvec_arbiter.sv
// Round-robin AXI-Stream arbiter sharing one matrix-vector engine between N requesters.
// Results return in issue order and are routed by an in-flight tag FIFO. Optional stats: MATVEC_ARB_STATS_EN.
module axis_matvec_arbiter #(
    parameter int N     = 4,
    parameter int W_S   = 64,
    parameter int W_M   = 32,
    parameter int DEPTH = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [N-1:0]       s_valid,
    output logic [N-1:0]       s_ready,
    input  logic [N*W_S-1:0]   s_data,
    output logic               e_valid,
    input  logic               e_ready,
    output logic [W_S-1:0]     e_data,
    input  logic               r_valid,
    output logic               r_ready,
    input  logic [W_M-1:0]     r_data,
    output logic [N-1:0]       m_valid,
    input  logic [N-1:0]       m_ready,
`ifdef MATVEC_ARB_STATS_EN
    output logic [N*16-1:0]    stat_cnt,
    output logic               err,
`endif
    output logic [N*W_M-1:0]   m_data
);

    localparam int IW = $clog2(N);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {ST_OPEN, ST_LOCKED} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_rr;
    logic [IW-1:0]   r_lock_idx;
    logic [IW-1:0]   w_scan_idx;
    logic [IW-1:0]   w_grant;
    logic [IW-1:0]   w_head;
    logic [IW-1:0]   r_tag_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_full;
    logic            w_empty;
    logic            w_e_valid;
    logic            w_push;
    logic            w_pop;

    // Round-robin scan: walk from farthest to nearest so the nearest valid requester after r_rr wins.
    always_comb begin
        int idx;
        // NOTE: every comb output gets a default first, otherwise a missed path infers a latch.
        w_scan_idx = r_rr;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(r_rr) + k) % N;
            if (s_valid[idx]) w_scan_idx = IW'(idx);
        end
    end

    // Lock FSM: holds the grant while the engine stalls so e_data stays stable.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rstn) r_state <= ST_OPEN;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_OPEN:   if (w_e_valid && !e_ready) w_state_nxt = ST_LOCKED;
            ST_LOCKED: if (w_push)                w_state_nxt = ST_OPEN;
            default:                              w_state_nxt = ST_OPEN;
        endcase
    end

    always_comb begin
        w_grant = (r_state == ST_LOCKED) ? r_lock_idx : w_scan_idx;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_lock_idx <= '0;
            r_rr       <= IW'(N - 1);
        end else begin
            if (r_state == ST_OPEN && w_e_valid && !e_ready) r_lock_idx <= w_grant;
            if (w_push)                                      r_rr       <= w_grant;
        end
    end

    // Issue side; outputs are also gated by rstn so they drop the moment reset asserts.
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_e_valid = s_valid[w_grant] && !w_full;
    assign e_valid   = rstn && w_e_valid;
    assign s_ready   = (rstn && e_ready && !w_full) ? (N'(1) << w_grant) : '0;
    assign w_push    = e_valid && e_ready;

    always_comb begin
        e_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant == IW'(i)) e_data = s_data[i*W_S +: W_S];
        end
    end

    // Return side: the FIFO head names the requester owning the current result.
    assign w_head  = r_tag_mem[r_rd_ptr];
    assign r_ready = rstn && !w_empty && m_ready[w_head];
    assign m_valid = (rstn && r_valid && !w_empty) ? (N'(1) << w_head) : '0;
    assign m_data  = {N{r_data}};
    assign w_pop   = r_valid && r_ready;

    // NOTE: tag storage is not reset; only pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) r_tag_mem[r_wr_ptr] <= w_grant;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef MATVEC_ARB_STATS_EN
    logic [N-1:0][15:0] r_stat;
    logic               r_err;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stat <= '0;
            r_err  <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (w_push && w_grant == IW'(i) && r_stat[i] != 16'hFFFF) r_stat[i] <= r_stat[i] + 16'd1;
            end
            if (r_valid && w_empty) r_err <= 1'b1;
        end
    end

    assign stat_cnt = r_stat;
    assign err      = r_err;
`endif

endmodule

// File: tb/tb_axis_matvec_arbiter.sv
// Self-checking bench for axis_matvec_arbiter: directed scenarios followed by a randomized run
// against a queue-based reference model.
module tb_axis_matvec_arbiter;

    localparam int N     = 4;
    localparam int W_S   = 64;
    localparam int W_M   = 32;
    localparam int DEPTH = 8;

    logic               clk = 1'b0;
    logic               rstn;
    logic [N-1:0]       s_valid;
    logic [N-1:0]       s_ready;
    logic [N*W_S-1:0]   s_data;
    logic               e_valid;
    logic               e_ready;
    logic [W_S-1:0]     e_data;
    logic               r_valid;
    logic               r_ready;
    logic [W_M-1:0]     r_data;
    logic [N-1:0]       m_valid;
    logic [N-1:0]       m_ready;
    logic [N*W_M-1:0]   m_data;
`ifdef MATVEC_ARB_STATS_EN
    logic [N*16-1:0]    stat_cnt;
    logic               err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    axis_matvec_arbiter #(.N(N), .W_S(W_S), .W_M(W_M), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .e_valid  (e_valid),
        .e_ready  (e_ready),
        .e_data   (e_data),
        .r_valid  (r_valid),
        .r_ready  (r_ready),
        .r_data   (r_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
`ifdef MATVEC_ARB_STATS_EN
        .stat_cnt (stat_cnt),
        .err      (err),
`endif
        .m_data   (m_data)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W_S-1:0] job_of(input int i);
        return {32'(32'hC0DE_0000 + i), 32'(32'h0000_1000 + i)};
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic drive_idle();
        s_valid = '0;
        e_ready = 1'b0;
        r_valid = 1'b0;
        m_ready = '0;
        r_data  = '0;
        for (int i = 0; i < N; i++) s_data[i*W_S +: W_S] = job_of(i);
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        drive_idle();
        tick();
        tick();
        rstn = 1'b1;
    endtask

    // Reference model state for the randomized phase.
    int            m_rr;
    int            m_lock;
    int            m_tags[$];
    int            m_cnt[N];
    logic [N-1:0]  accepted;

    initial begin
        int hs;
        int g;
        int head;
        int idx;
        bit full;
        bit exp_ev;
        bit exp_rr;
        logic [N-1:0] exp_sr;
        logic [N-1:0] exp_mv;

        // Outputs must be quiet while reset is held, even with active inputs.
        rstn    = 1'b0;
        drive_idle();
        s_valid = '1;
        e_ready = 1'b1;
        r_valid = 1'b1;
        m_ready = '1;
        #1;
        check("reset_s_ready", s_ready, '0);
        check("reset_e_valid", e_valid, 1'b0);
        check("reset_r_ready", r_ready, 1'b0);
        check("reset_m_valid", m_valid, '0);
        tick();

        // Fairness: all requesters valid, grants rotate starting at 0.
        apply_reset();
        s_valid = '1;
        e_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("fair_grant", s_ready, onehot(k % N));
            check("fair_edata", e_data, job_of(k % N));
            tick();
        end
        s_valid = '0;
        e_ready = 1'b0;
        r_valid = 1'b1;
        m_ready = '1;
        for (int k = 0; k < 6; k++) begin
            r_data = 32'hBEEF_0000 + 32'(k);
            #1;
            check("fair_m_valid", m_valid, onehot(k % N));
            check("fair_m_data", m_data[(k % N)*W_M +: W_M], 32'hBEEF_0000 + 32'(k));
            check("fair_r_ready", r_ready, 1'b1);
            tick();
        end
        r_valid = 1'b0;

        // Lock: a stalled grant to 2 is not preempted by requester 0.
        apply_reset();
        s_valid = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("lock_e_valid", e_valid, 1'b1);
            check("lock_e_data", e_data, job_of(2));
            check("lock_s_ready", s_ready, '0);
            tick();
        end
        s_valid = 4'b0101;
        #1;
        check("lock_hold_data", e_data, job_of(2));
        tick();
        e_ready = 1'b1;
        #1;
        check("lock_grant2", s_ready, 4'b0100);
        tick();
        s_valid = 4'b0001;
        #1;
        check("lock_then0", s_ready, 4'b0001);
        check("lock_then0_data", e_data, job_of(0));
        tick();

        // Full: only DEPTH jobs accepted; a pop frees a slot only on the following cycle.
        apply_reset();
        s_valid = '1;
        e_ready = 1'b1;
        hs = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            hs += int'(e_valid);
            tick();
        end
        check("full_handshakes", hs, DEPTH);
        #1;
        check("full_e_valid", e_valid, 1'b0);
        r_valid = 1'b1;
        m_ready = '1;
        #1;
        check("full_pop_r_ready", r_ready, 1'b1);
        check("full_no_bypass", e_valid, 1'b0);
        check("full_no_bypass_sr", s_ready, '0);
        tick();
        r_valid = 1'b0;
        #1;
        check("full_reissue", e_valid, 1'b1);
        check("full_reissue_sr", s_ready, 4'b0001);
        tick();
        #1;
        check("full_again", e_valid, 1'b0);
        tick();

        // Return backpressure on head tag 1.
        apply_reset();
        s_valid = 4'b0010;
        e_ready = 1'b1;
        #1;
        check("bp_issue", s_ready, 4'b0010);
        tick();
        s_valid = '0;
        e_ready = 1'b0;
        r_valid = 1'b1;
        r_data  = 32'h1234_5678;
        m_ready = 4'b1101;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_r_ready", r_ready, 1'b0);
            check("bp_m_valid", m_valid, 4'b0010);
            tick();
        end
        m_ready = '1;
        #1;
        check("bp_release_r_ready", r_ready, 1'b1);
        check("bp_release_m_data", m_data[1*W_M +: W_M], 32'h1234_5678);
        tick();
        #1;
        check("empty_r_ready", r_ready, 1'b0);
        check("empty_m_valid", m_valid, '0);
        tick();
        r_valid = 1'b0;

        // Simultaneous push/pop at count 3 across pointer wrap.
        apply_reset();
        s_valid = '1;
        e_ready = 1'b1;
        tick();
        tick();
        tick();
        r_valid = 1'b1;
        m_ready = '1;
        for (int k = 0; k < 8; k++) begin
            r_data = 32'(k);
            #1;
            check("pp_head", m_valid, onehot(k % N));
            check("pp_grant", s_ready, onehot((3 + k) % N));
            check("pp_r_ready", r_ready, 1'b1);
            tick();
        end
        r_valid = 1'b0;
        hs = 0;
        for (int k = 0; k < 7; k++) begin
            #1;
            hs += int'(e_valid);
            tick();
        end
        check("pp_count3", hs, DEPTH - 3);

        // Reset with five jobs in flight.
        apply_reset();
        s_valid = '1;
        e_ready = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        r_valid = 1'b1;
        m_ready = '1;
        #1;
        check("mid_r_ready_pre", r_ready, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        check("mid_s_ready", s_ready, '0);
        check("mid_e_valid", e_valid, 1'b0);
        check("mid_r_ready", r_ready, 1'b0);
        check("mid_m_valid", m_valid, '0);
        tick();
        rstn = 1'b1;
        #1;
        check("mid_first_grant", s_ready, 4'b0001);
        check("mid_fifo_empty", r_ready, 1'b0);
        check("mid_no_route", m_valid, '0);
`ifdef MATVEC_ARB_STATS_EN
        check("stat_cleared", stat_cnt, '0);
        check("err_cleared", err, 1'b0);
`endif
        tick();
`ifdef MATVEC_ARB_STATS_EN
        check("err_set", err, 1'b1);
        check("stat_one", stat_cnt, 64'h1);
`endif

        // Randomized traffic against the queue model.
        apply_reset();
        m_rr   = N - 1;
        m_lock = -1;
        m_tags.delete();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!s_valid[i] && $urandom_range(0, 2) == 0) begin
                    s_valid[i] = 1'b1;
                    s_data[i*W_S +: W_S] = {$urandom, $urandom};
                end
            end
            e_ready = ($urandom_range(0, 3) != 0);
            r_valid = (m_tags.size() > 0) && ($urandom_range(0, 2) == 0);
            m_ready = N'($urandom);
            r_data  = $urandom;
            #1;

            full = (m_tags.size() == DEPTH);
            g = m_lock;
            if (g < 0) begin
                for (int k = 1; k <= N; k++) begin
                    idx = (m_rr + k) % N;
                    if (g < 0 && s_valid[idx]) g = idx;
                end
            end
            exp_ev = (g >= 0) && s_valid[g] && !full;
            exp_sr = ((g >= 0) && e_ready && !full) ? onehot(g) : '0;
            head   = (m_tags.size() > 0) ? m_tags[0] : -1;
            exp_rr = (head >= 0) && m_ready[head];
            exp_mv = ((head >= 0) && r_valid) ? onehot(head) : '0;

            check("rnd_e_valid", e_valid, exp_ev);
            if (exp_ev) check("rnd_e_data", e_data, s_data[g*W_S +: W_S]);
            check("rnd_s_ready", s_ready & s_valid, exp_sr & s_valid);
            check("rnd_r_ready", r_ready, exp_rr);
            check("rnd_m_valid", m_valid, exp_mv);
            if (exp_mv != '0) check("rnd_m_data", m_data[head*W_M +: W_M], r_data);

            accepted = '0;
            if (r_valid && exp_rr) void'(m_tags.pop_front());
            if (exp_ev && e_ready) begin
                m_tags.push_back(g);
                m_rr   = g;
                m_lock = -1;
                accepted[g] = 1'b1;
                if (m_cnt[g] < 16'hFFFF) m_cnt[g]++;
            end else if (exp_ev) begin
                m_lock = g;
            end
            tick();
            s_valid = s_valid & ~accepted;
        end
`ifdef MATVEC_ARB_STATS_EN
        for (int i = 0; i < N; i++) check("rnd_stat_cnt", stat_cnt[i*16 +: 16], 16'(m_cnt[i]));
        check("rnd_err_clear", err, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
